stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  write din onto stack at next clk edge.
REQ-006 pop  input  1  remove top entry at next clk edge.
REQ-007 din  input  WIDTH  data to push (ALU result or MDR, selected upstream).
REQ-008 err_clr  input  1  synchronous clear of sticky error flags.
REQ-009 dout  output  WIDTH  current top-of-stack value, combinational from registered state.
REQ-010 tos_zero  output  1  high when dout == 0.
REQ-011 empty  output  1  high when count == 0.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 overflow  output  1  sticky: push refused because stack was full.
REQ-015 underflow  output  1  sticky: pop requested while stack was empty.

Function
REQ-016 dout SHALL present mem[count-1] in the same cycle pop is asserted, so the controller can load an operand and pop in one cycle.
REQ-017 dout SHALL be 0 when empty; tos_zero is therefore 1 when empty.
REQ-018 Push only, not full: mem[count] <= din, count +1; new value visible on dout the next cycle.
REQ-019 Push only, full: storage and count unchanged; overflow <= 1.
REQ-020 Pop only, not empty: count -1; popped entry contents not required to be cleared.
REQ-021 Pop only, empty: count stays 0; underflow <= 1.
REQ-022 Push and pop, count > 0: replace top, mem[count-1] <= din, count unchanged, no overflow even when full.
REQ-023 Push and pop, empty: underflow <= 1; push proceeds, mem[0] <= din, count becomes 1.
REQ-024 Neither asserted: all state holds.
REQ-025 err_clr SHALL clear overflow and underflow; an error event in the same cycle wins and sets its flag.
REQ-026 count SHALL never exceed DEPTH nor go below 0; no wrap-around of the pointer.
REQ-027 Latency: one clk from push/pop to updated count, empty, full, dout and tos_zero.

Reset
REQ-028 reset SHALL asynchronously force count=0, overflow=0, underflow=0; hence empty=1, full=0, dout=0, tos_zero=1.
REQ-029 Storage array SHALL NOT require reset; its contents are unobservable while empty.
REQ-030 Reset asserted mid-operation SHALL discard any push/pop sampled on that edge.

Structure
REQ-031 WIDTH and DEPTH defaults SHALL be constants in the shared CPU package, next to the opcode encodings used by the controller.
REQ-032 The block SHALL be one module with an inline register array; no sub-module.

Verification
REQ-033 Reset, then push 0x05, 0x00, 0x7F -> count=3, dout=0x7F, tos_zero=0; pop -> dout=0x00, tos_zero=1; pop -> dout=0x05.
REQ-034 Push 8 values 0x01..0x08, then push 0x09 -> full=1, overflow=1, count=8, dout=0x08.
REQ-035 From empty, pop -> underflow=1, count=0, dout=0; assert err_clr -> underflow=0 on next cycle.
REQ-036 count=2 with top 0x33, push=pop=1 with din=0x44 -> count=2, dout=0x44, no flags set.
REQ-037 Full stack, push=pop=1 with din=0xAA -> count=8, dout=0xAA, overflow=0.
REQ-038 Assert reset between clk edges with count=5 -> count=0, empty=1, dout=0 immediately, before the next edge.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// Shared CPU package: datapath sizing defaults and the encodings used by the
// controller and the operand stack.
package stack_unit_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_PUSH = 4'h1,
        OP_POP  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_DUP  = 4'h5,
        OP_JZ   = 4'h6,
        OP_HALT = 4'hF
    } opcode_e;

    // Stack request as seen on the {push, pop} strobe pair.
    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_POP  = 2'b01,
        STK_PUSH = 2'b10,
        STK_REPL = 2'b11
    } stack_op_e;

endpackage

// File: rtl/stack_unit.sv
// Operand stack for the CPU datapath: inline register array, saturating
// occupancy count and sticky overflow/underflow flags.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         dout,
    output logic                     tos_zero,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    stack_op_e        w_op;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_dout;

    assign w_op      = stack_op_e'({push, pop});
    assign w_empty   = (r_count == CW'(0));
    assign w_full    = (r_count == CW'(DEPTH));
    // Low bits of a full count wrap to 0, so subtracting one still lands on DEPTH-1.
    assign w_top_idx = r_count[AW-1:0] - AW'(1);
    assign w_wr_en   = push && (pop || !w_full);

    // Write slot: replace the top on push+pop with data, otherwise the next free entry.
    always_comb begin
        w_wr_idx = r_count[AW-1:0];
        if (pop && !w_empty) begin
            w_wr_idx = w_top_idx;
        end else begin
            w_wr_idx = r_count[AW-1:0];
        end
    end

    // Top-of-stack read, forced to zero while empty.
    always_comb begin
        w_dout = '0;
        if (w_empty) begin
            w_dout = '0;
        end else begin
            w_dout = r_mem[w_top_idx];
        end
    end

    // Storage array; deliberately not reset since it is unobservable while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Occupancy count and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= CW'(0);
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                STK_PUSH: if (!w_full)  r_count <= r_count + CW'(1);
                STK_POP:  if (!w_empty) r_count <= r_count - CW'(1);
                STK_REPL: if (w_empty)  r_count <= CW'(1);
                default:  r_count <= r_count;
            endcase

            if (w_op == STK_PUSH && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end

            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dout      = w_dout;
    assign tos_zero  = (w_dout == '0);
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus pushes the reference model's
// post-edge view into a queue, a monitor pops and compares after every edge.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             tos_zero;
    logic             empty;
    logic             full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    typedef struct {
        int cnt;
        int top;
        bit tz;
        bit emp;
        bit ful;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stk[$];
    bit         m_ovf;
    bit         m_unf;
    int         checks   = 0;
    int         failures = 0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .err_clr(err_clr), .dout(dout), .tos_zero(tos_zero), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.cnt = stk.size();
        e.top = (stk.size() == 0) ? 0 : int'(stk[stk.size()-1]);
        e.tz  = (e.top == 0);
        e.emp = (stk.size() == 0);
        e.ful = (stk.size() == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    // Reference behaviour of one clock edge, from the stack rules directly.
    task automatic model_step(input bit p, input bit q, input logic [7:0] d, input bit c);
        bit of_ev = p && !q && (stk.size() == DEPTH);
        bit uf_ev = q && (stk.size() == 0);
        if (p && q) begin
            if (stk.size() > 0) stk[stk.size()-1] = d;
            else stk.push_back(d);
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(d);
        end else if (q) begin
            if (stk.size() > 0) void'(stk.pop_back());
        end
        m_ovf = of_ev ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = uf_ev ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit c);
        @(negedge clk);
        push = p; pop = q; din = d; err_clr = c;
        model_step(p, q, d, c);
        exp_q.push_back(model_view());
    endtask

    task automatic chk_now(input string tag);
        exp_t e = model_view();
        chk({tag, ".count"},     int'(count),     e.cnt);
        chk({tag, ".dout"},      int'(dout),      e.top);
        chk({tag, ".tos_zero"},  int'(tos_zero),  int'(e.tz));
        chk({tag, ".empty"},     int'(empty),     int'(e.emp));
        chk({tag, ".full"},      int'(full),      int'(e.ful));
        chk({tag, ".overflow"},  int'(overflow),  int'(e.ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(e.unf));
    endtask

    // Reset raised between edges with a push pending: effect must be immediate
    // and the push sampled during reset must be discarded.
    task automatic reset_mid();
        @(negedge clk);
        push = 1'b1; pop = 1'b0; din = 8'h5A; err_clr = 1'b0;
        #2;
        reset = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        chk_now("reset_async");
        @(negedge clk);
        push = 1'b0;
        reset = 1'b0;
        #1;
        chk_now("reset_discard");
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",     int'(count),     e.cnt);
                chk("dout",      int'(dout),      e.top);
                chk("tos_zero",  int'(tos_zero),  int'(e.tz));
                chk("empty",     int'(empty),     int'(e.emp));
                chk("full",      int'(full),      int'(e.ful));
                chk("overflow",  int'(overflow),  int'(e.ovf));
                chk("underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    initial begin
        int wait_cycles;
        int r;
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00; err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_now("reset_state");

        // Basic push/pop with a zero value on the stack.
        step(1, 0, 8'h05, 0); step(1, 0, 8'h00, 0); step(1, 0, 8'h7F, 0);
        step(0, 1, 8'h00, 0); step(0, 1, 8'h00, 0); step(0, 1, 8'h00, 0);

        // Fill, overflow, then replace-top while full.
        for (int i = 1; i <= 9; i++) step(1, 0, 8'(i), 0);
        step(1, 1, 8'hAA, 0);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

        // Underflow, clear, then push+pop on empty.
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h21, 0);
        step(1, 0, 8'h33, 0);
        step(1, 1, 8'h44, 0);
        // Error event beats err_clr in the same cycle.
        for (int i = 0; i < 2; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1);

        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i), 0);
        reset_mid();

        // Randomised phases biased toward filling, draining and mixing.
        for (int i = 0; i < 600; i++) begin
            int bias = (i / 100) % 3;
            bit p, q;
            r = $urandom_range(0, 9);
            case (bias)
                0:       begin p = (r < 7); q = (r >= 5); end
                1:       begin p = (r < 3); q = (r >= 2); end
                default: begin p = r[0];    q = r[1];     end
            endcase
            step(p, q, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            if (i % 150 == 149) reset_mid();
        end

        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        chk("drain_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
